vga_fb_reader: RTL and testbench
================================

VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal front porch, sync and back porch widths in clocks.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP, 10; V_SYNC, 2; V_BP, 33: vertical front porch, sync and back porch widths in lines.
REQ-005 Port clk  in  1  pixel clock (25 MHz nominal); the only clock.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port re  out  1  frame-buffer read enable.
REQ-008 Port read_addr  out  20  frame-buffer pixel address.
REQ-009 Port pix_in  in  8  frame-buffer read data, valid one clock after re.
REQ-010 Port pattern_sel  in  1  selects the test pattern (see Configuration).
REQ-011 Port vga_r, vga_g, vga_b  out  4 each  pixel colour.
REQ-012 Port hsync, vsync  out  1 each  active-low syncs.
REQ-013 Port frame_start  out  1  one-clock pulse marking the first visible pixel of a frame.

Function
REQ-014 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters (800); it wraps to 0 and advances v_cnt.
REQ-015 v_cnt SHALL count 0..V_TOTAL-1, where V_TOTAL = sum of the four V parameters (525); it wraps to 0 after the last clock of line V_TOTAL-1.
REQ-016 Active region SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-017 Stage 1 (registered from counters): re=1 exactly in the active region; read_addr=current address counter.
REQ-018 Address counter SHALL increment by 1 per active pixel, run 0..H_ACTIVE*V_ACTIVE-1 (0..307199), and return to 0 at h_cnt=0, v_cnt=0.
REQ-019 The block SHALL use no multiplier for address generation.
REQ-020 Stage 2: pix_in valid (fixed one-clock RAM read latency).
REQ-021 Stage 3 (registered): in the active region, vga_r=vga_g=vga_b=pix_in[7:4] (greyscale); otherwise all 0.
REQ-022 Raw hsync SHALL be low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
REQ-023 Raw vsync SHALL be low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491).
REQ-024 Raw syncs and the active flag SHALL pass through a 3-stage delay so hsync, vsync and rgb are mutually aligned; total latency from counter to output is 3 clocks.
REQ-025 frame_start SHALL pulse on the same clock that the pixel for address 0 appears on rgb.
REQ-026 re SHALL be 0 and read_addr SHALL hold its last value throughout blanking.

Reset
REQ-027 While reset is high: h_cnt, v_cnt and the address counter SHALL be 0; re=0; read_addr=0; rgb=0; hsync=1; vsync=1; frame_start=0; all delay stages SHALL be cleared to these inactive values.
REQ-028 Assertion of reset mid-frame SHALL take effect immediately (asynchronous); after release the scan SHALL restart at h_cnt=0, v_cnt=0, address 0.

Configuration
REQ-029 Macro VGA_TEST_PATTERN_EN.
REQ-030 Macro defined: when pattern_sel=1, active pixels SHALL show 8 vertical bars each 80 pixels wide (bar k = h_cnt/80), coloured by {r,g,b} = {k[2],k[1],k[0]} each expanded to 4'hF or 4'h0; timing and re/read_addr are unchanged.
REQ-031 Macro undefined: pattern_sel SHALL be ignored; pixels always come from pix_in.

Verification
REQ-032 Release reset; pix_in=8'hA5 -> re=1 and read_addr=0 at clock 1; rgb=4'hA/4'hA/4'hA at clock 3, coinciding with the frame_start pulse.
REQ-033 Free run for one line -> hsync low for exactly 96 clocks, first low at clock 659 after release; re high for exactly 640 clocks per line.
REQ-034 Free run for a full frame -> read_addr reaches 307199 on line 479, pixel 639; the next active pixel reads address 0; vsync low for exactly 2×800 clocks; frame period is 420000 clocks.
REQ-035 During blanking, drive pix_in=8'hFF -> rgb stays 0.
REQ-036 Assert reset at line 100, pixel 300 for 2 clocks -> outputs immediately take reset values; after release read_addr restarts at 0.
REQ-037 With VGA_TEST_PATTERN_EN defined and pattern_sel=1 -> pixel 0 is 0/0/0 and pixel 639 is F/F/F, while read_addr sequencing matches REQ-034.

Source files
------------

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: VGA scan generator streaming 8-bit greyscale from a frame buffer.
// Ports: clk, reset (async, active high); re/read_addr/pix_in frame-buffer read
// port (1-clock latency); pattern_sel; vga_r/g/b 4-bit colour; hsync/vsync
// active low; frame_start. Define VGA_TEST_PATTERN_EN to enable colour bars.
module vga_fb_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  output logic        re,
  output logic [19:0] read_addr,
  input  logic [7:0]  pix_in,
  input  logic        pattern_sel,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [19:0]   addr_q, addr_d;
  logic          re_q, re_d;
  logic [19:0]   read_addr_q, read_addr_d;
  logic [2:0]    hs_q, hs_d;
  logic [2:0]    vs_q, vs_d;
  logic [2:0]    fs_q, fs_d;
  logic          act2_q, act2_d;
  logic [11:0]   rgb_q, rgb_d;

  logic active;
  logic h_end;
  logic frame_end;
  logic unused_ok;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = $clog2(BAR_W);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [BW-1:0] bar_px_q, bar_px_d;
  logic [2:0]    bar_k_q, bar_k_d;
  logic [2:0]    bar1_q, bar1_d;
  logic [2:0]    bar2_q, bar2_d;

  // Bar index tracks h_cnt/BAR_W with a wrap counter instead of a divider.
  always_comb begin
    bar_px_d = bar_px_q + 1'b1;
    bar_k_d  = bar_k_q;
    if (h_end) begin
      bar_px_d = '0;
      bar_k_d  = '0;
    end else if (bar_px_q == BAR_LAST) begin
      bar_px_d = '0;
      bar_k_d  = bar_k_q + 1'b1;
    end
    bar1_d = bar_k_q;
    bar2_d = bar1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bar_px_q <= '0;
      bar_k_q  <= '0;
      bar1_q   <= '0;
      bar2_q   <= '0;
    end else begin
      bar_px_q <= bar_px_d;
      bar_k_q  <= bar_k_d;
      bar1_q   <= bar1_d;
      bar2_q   <= bar2_d;
    end
  end

  assign unused_ok = ^pix_in[3:0];
`else
  assign unused_ok = ^{pattern_sel, pix_in[3:0]};
`endif

  always_comb begin
    h_end     = (h_cnt_q == H_LAST);
    frame_end = h_end && (v_cnt_q == V_LAST);
    active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    h_cnt_d = h_end ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (frame_end) v_cnt_d = '0;
    else if (h_end) v_cnt_d = v_cnt_q + 1'b1;

    // Running address replaces v*H_ACTIVE+h; cleared at frame wrap.
    addr_d = addr_q;
    if (frame_end) addr_d = '0;
    else if (active) addr_d = addr_q + 1'b1;

    re_d        = active;
    read_addr_d = active ? addr_q : read_addr_q;

    hs_d = {hs_q[1:0], ~((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END))};
    vs_d = {vs_q[1:0], ~((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END))};
    fs_d = {fs_q[1:0], (h_cnt_q == '0) && (v_cnt_q == '0)};

    act2_d = re_q;
    rgb_d  = act2_q ? {3{pix_in[7:4]}} : '0;
`ifdef VGA_TEST_PATTERN_EN
    if (act2_q && pattern_sel)
      rgb_d = {{4{bar2_q[2]}}, {4{bar2_q[1]}}, {4{bar2_q[0]}}};
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      addr_q      <= '0;
      re_q        <= 1'b0;
      read_addr_q <= '0;
      hs_q        <= 3'b111;
      vs_q        <= 3'b111;
      fs_q        <= '0;
      act2_q      <= 1'b0;
      rgb_q       <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      addr_q      <= addr_d;
      re_q        <= re_d;
      read_addr_q <= read_addr_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
      act2_q      <= act2_d;
      rgb_q       <= rgb_d;
    end
  end

  assign re          = re_q;
  assign read_addr   = read_addr_q;
  assign hsync       = hs_q[2];
  assign vsync       = vs_q[2];
  assign frame_start = fs_q[2];
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: randomized frame-buffer bench with an arithmetic scan model.
// Uses a 20-line frame to keep full-frame runs short.
module tb_vga_fb_reader;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 20,  VF = 2,  VS = 2,  VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NPIX = HA * VA;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        re;
  logic [19:0] read_addr;
  logic [7:0]  pix_in = 8'h00;
  logic        pattern_sel = 1'b0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        hsync, vsync, frame_start;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] seed;
  int          k, exp_ra, last_fs, first_hs;
  int          run_re, run_hs, run_vs;
  logic        prev_re, prev_hs, prev_vs;
  logic [7:0]  pend;
  bit          mid_done, done;

  vga_fb_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .re(re), .read_addr(read_addr),
    .pix_in(pix_in), .pattern_sel(pattern_sel),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] mem_rd(input int a);
    logic [31:0] x;
    x = (32'(a) ^ seed) * 32'h9e3779b1;
    return x[31:24];
  endfunction

  function automatic bit is_act(input int p);
    return (p % HT) < HA && ((p / HT) % VT) < VA;
  endfunction

  function automatic int p_addr(input int p);
    return ((p / HT) % VT) * HA + (p % HT);
  endfunction

  function automatic logic [11:0] exp_rgb(input int p);
    logic [7:0] d;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
    if (p < 0 || !is_act(p)) return '0;
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel) begin
      bar = 3'((p % HT) / 80);
      return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
    end
`endif
    d = mem_rd(p_addr(p));
    return {d[7:4], d[7:4], d[7:4]};
  endfunction

  task automatic restart();
    k = 0;
    exp_ra = 0;
    last_fs = -1;
    first_hs = -1;
    run_re = 0;
    run_hs = 0;
    run_vs = 0;
    prev_re = 1'b0;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
  endtask

  task automatic chk_reset_vals(input string ph);
    chk({ph, "_re"}, 32'(re), 32'd0);
    chk({ph, "_raddr"}, 32'(read_addr), 32'd0);
    chk({ph, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk({ph, "_hs"}, 32'(hsync), 32'd1);
    chk({ph, "_vs"}, 32'(vsync), 32'd1);
    chk({ph, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  task automatic cycle_checks();
    int p1, p3, h3, v3;
    p1 = k - 1;
    p3 = k - 3;
    if (p1 >= 0 && is_act(p1)) exp_ra = p_addr(p1);
    chk("re", 32'(re), 32'(p1 >= 0 && is_act(p1)));
    chk("raddr", 32'(read_addr), 32'(exp_ra));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb(p3)));
    h3 = (p3 < 0) ? 0 : p3 % HT;
    v3 = (p3 < 0) ? 0 : (p3 / HT) % VT;
    chk("hsync", 32'(hsync),
        32'(p3 < 0 || !(h3 >= HA + HF && h3 < HA + HF + HS)));
    chk("vsync", 32'(vsync),
        32'(p3 < 0 || !(v3 >= VA + VF && v3 < VA + VF + VS)));
    chk("fstart", 32'(frame_start), 32'(p3 >= 0 && p3 % FRAME == 0));

    if (p1 == (VA - 1) * HT + HA - 1)
      chk("addr_last", 32'(read_addr), 32'(NPIX - 1));
    if (first_hs < 0 && hsync == 1'b0) begin
      first_hs = k;
      chk("hs_first", 32'(k), 32'(HA + HF + 3));
    end
    if (re) run_re++;
    else begin
      if (prev_re) chk("re_len", 32'(run_re), 32'(HA));
      run_re = 0;
    end
    if (!hsync) run_hs++;
    else begin
      if (!prev_hs) chk("hs_len", 32'(run_hs), 32'(HS));
      run_hs = 0;
    end
    if (!vsync) run_vs++;
    else begin
      if (!prev_vs) chk("vs_len", 32'(run_vs), 32'(VS * HT));
      run_vs = 0;
    end
    if (frame_start) begin
      if (last_fs < 0) chk("fs_first", 32'(k), 32'd3);
      else chk("fs_period", 32'(k - last_fs), 32'(FRAME));
      last_fs = k;
    end
    prev_re = re;
    prev_hs = hsync;
    prev_vs = vsync;
  endtask

  initial begin
    seed = $urandom;
    pend = 8'($urandom);
    mid_done = 1'b0;
    done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;
    restart();
    while (!done) begin
      @(posedge clk);
      #1;
      k++;
      cycle_checks();
      pix_in = pend;
      if (re) pend = mem_rd(int'(read_addr));
      else pend = $urandom_range(1) ? 8'hFF : 8'($urandom);
`ifdef VGA_TEST_PATTERN_EN
      pattern_sel = (k >= FRAME);
`else
      pattern_sel = 1'($urandom);
`endif
      if (!mid_done && k == FRAME + 10 * HT + 300) begin
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_vals("mid");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("hold");
        @(negedge clk);
        reset = 1'b0;
        restart();
        mid_done = 1'b1;
      end else if (mid_done && k == 3000) begin
        done = 1'b1;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
